mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage. It replaces the fixed 32-bit single-purpose mult/div path with a DATA_W-generic engine that adds cancel-on-exception, a result-hold handshake for bus stalls, defined divide-by-zero behaviour and optional multiply-accumulate. Results are returned as HI:LO for the HI/LO write path.

---
 rtl/mul_div_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide engine for the execute stage.
// Produces {HI,LO} for mult/multu (product) and div/divu (remainder/quotient).
// One result bit per cycle over DATA_W cycles. Sign fix-up follows in a
// separate cycle. An optional multiply-accumulate cycle comes after that.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, op         request and operation (00 multu, 01 mult, 10 divu, 11 div)
//   acc_mode          00 none, 01 madd, 10 msub, 11 none
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   hilo_in           current {HI,LO}, used only for accumulate
//   cancel            exception flush, returns to IDLE from any state
//   is_busbusy        downstream stall, holds the result in DONE
//   ready             idle, a request can be accepted
//   opreat_over       result valid
//   hi_out, lo_out    remainder/product-high, quotient/product-low
//   div_by_zero       divisor was zero (valid with opreat_over)
//
// Build option: define MUL_DIV_ACC_EN to enable madd/msub. This adds the ACC
// state and the 2*DATA_W adder.
module mul_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [1:0]          acc_mode,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  input  logic [2*DATA_W-1:0] hilo_in,
  input  logic                cancel,
  input  logic                is_busbusy,
  output logic                ready,
  output logic                opreat_over,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output logic                div_by_zero
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
`ifdef MUL_DIV_ACC_EN
    ACC,
`endif
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;       // |a| for multiply, |b| for divide
  logic [DATA_W-1:0] a_raw_q, a_raw_d;     // dividend before abs, for div-by-zero HI
  logic              b_zero_q, b_zero_d;
  logic              neg_res_q, neg_res_d; // negate product / quotient
  logic              neg_rem_q, neg_rem_d; // negate remainder
  logic [DATA_W-1:0] work_hi_q, work_hi_d; // partial product high / remainder
  logic [DATA_W-1:0] work_lo_q, work_lo_d; // multiplier / dividend->quotient
  logic [DATA_W-1:0] hi_out_q, hi_out_d;
  logic [DATA_W-1:0] lo_out_q, lo_out_d;
  logic              dbz_q, dbz_d;

  logic              accept;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift, div_diff;
  logic              div_take;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic              acc_hit;

`ifdef MUL_DIV_ACC_EN
  logic [1:0]          acc_q, acc_d;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic [2*DATA_W-1:0] acc_sum;
`else
  logic unused_acc_inputs;
  assign unused_acc_inputs = ^{acc_mode, hilo_in};
`endif

  assign accept = (state_q == IDLE) && start && !cancel;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = CALC;
        CALC: if (cnt_q == CNT_LAST) state_d = FIX;
        FIX:  state_d = acc_hit ?
`ifdef MUL_DIV_ACC_EN
                        ACC
`else
                        DONE
`endif
                        : DONE;
`ifdef MUL_DIV_ACC_EN
        ACC:  state_d = DONE;
`endif
        DONE: if (!is_busbusy) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    ready       = (state_q == IDLE);
    opreat_over = (state_q == DONE);
  end

  // ---------------- datapath ----------------
  always_comb begin
    a_abs = (op[0] && src_a[DATA_W-1]) ? -src_a : src_a;
    b_abs = (op[0] && src_b[DATA_W-1]) ? -src_b : src_b;

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift {carry,hi,lo} right by one.
    mul_sum = work_lo_q[0] ? ({1'b0, work_hi_q} + {1'b0, opnd_q}) : {1'b0, work_hi_q};

    // Restoring divide step. The remainder is always below the divisor, so it
    // fits back into DATA_W bits.
    div_shift = {work_hi_q, work_lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_take  = (div_shift >= {1'b0, opnd_q});

    prod     = {work_hi_q, work_lo_q};
    prod_fix = neg_res_q ? -prod : prod;

`ifdef MUL_DIV_ACC_EN
    acc_hit = !op_q[1] && ((acc_q == 2'b01) || (acc_q == 2'b10));
    acc_sum = (acc_q == 2'b10) ? (hilo_q - {hi_out_q, lo_out_q})
                               : (hilo_q + {hi_out_q, lo_out_q});
`else
    acc_hit = 1'b0;
`endif
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    b_zero_d  = b_zero_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_out_d  = hi_out_q;
    lo_out_d  = lo_out_q;
    dbz_d     = dbz_q;
`ifdef MUL_DIV_ACC_EN
    acc_d     = acc_q;
    hilo_d    = hilo_q;
`endif

    if (accept) begin
      cnt_d     = '0;
      op_d      = op;
      opnd_d    = op[1] ? b_abs : a_abs;
      a_raw_d   = src_a;
      b_zero_d  = (src_b == '0);
      neg_res_d = op[0] && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      neg_rem_d = op[0] && src_a[DATA_W-1];
      work_hi_d = '0;
      work_lo_d = op[1] ? a_abs : b_abs;
`ifdef MUL_DIV_ACC_EN
      acc_d     = acc_mode;
      hilo_d    = hilo_in;
`endif
    end else if (!cancel) begin
      case (state_q)
        CALC: begin
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          if (op_q[1]) begin
            work_hi_d = div_take ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            work_lo_d = {work_lo_q[DATA_W-2:0], div_take};
          end else begin
            work_hi_d = mul_sum[DATA_W:1];
            work_lo_d = {mul_sum[0], work_lo_q[DATA_W-1:1]};
          end
        end
        FIX: begin
          if (!op_q[1]) begin
            hi_out_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_out_d = prod_fix[DATA_W-1:0];
            dbz_d    = 1'b0;
          end else if (b_zero_q) begin
            hi_out_d = a_raw_q;
            lo_out_d = '1;
            dbz_d    = 1'b1;
          end else begin
            // most-negative / -1 needs no special case: |a| = 2^(W-1),
            // the signs cancel, and the quotient wraps to most-negative.
            hi_out_d = neg_rem_q ? -work_hi_q : work_hi_q;
            lo_out_d = neg_res_q ? -work_lo_q : work_lo_q;
            dbz_d    = 1'b0;
          end
        end
`ifdef MUL_DIV_ACC_EN
        ACC: begin
          hi_out_d = acc_sum[2*DATA_W-1:DATA_W];
          lo_out_d = acc_sum[DATA_W-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      b_zero_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_out_q  <= '0;
      lo_out_q  <= '0;
      dbz_q     <= 1'b0;
`ifdef MUL_DIV_ACC_EN
      acc_q     <= '0;
      hilo_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      b_zero_q  <= b_zero_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_out_q  <= hi_out_d;
      lo_out_q  <= lo_out_d;
      dbz_q     <= dbz_d;
`ifdef MUL_DIV_ACC_EN
      acc_q     <= acc_d;
      hilo_q    <= hilo_d;
`endif
    end
  end

  assign hi_out      = hi_out_q;
  assign lo_out      = lo_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit (DATA_W = 32). It drives inputs and samples
// outputs on the falling clock edge. Expected results come from plain 64-bit
// arithmetic on the operation's definition.
`timescale 1ns/1ps
module tb_mul_div_unit;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [1:0]    acc_mode;
  logic [W-1:0]  src_a, src_b;
  logic [2*W-1:0] hilo_in;
  logic          cancel;
  logic          is_busbusy;
  logic          ready, opreat_over, div_by_zero;
  logic [W-1:0]  hi_out, lo_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mul_div_unit #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .acc_mode(acc_mode),
    .src_a(src_a), .src_b(src_b), .hilo_in(hilo_in), .cancel(cancel),
    .is_busbusy(is_busbusy), .ready(ready), .opreat_over(opreat_over),
    .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the result from the operation's arithmetic definition.
  function automatic void model(input logic [1:0] m_op, input logic [1:0] m_acc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] hilo,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    if (!m_op[1]) begin
      if (m_op[0]) p = 64'(sa * sb);
      else         p = {32'd0, a} * {32'd0, b};
`ifdef MUL_DIV_ACC_EN
      if (m_acc == 2'b01) p = hilo + p;
      else if (m_acc == 2'b10) p = hilo - p;
`else
      if (m_acc == 2'b11 && hilo == 64'd1) p = p; // accumulate has no effect in this build
`endif
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dbz = 1'b1;
      hi  = a;
      lo  = 32'hFFFF_FFFF;
    end else if (m_op[0]) begin
      q = sa / sb;
      r = sa % sb;
      qv = 64'(q);
      rv = 64'(r);
      lo = qv[31:0];
      hi = rv[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Waits (bounded) for ready, then presents one request. Returns in cycle 1.
  task automatic issue(input string tag, input logic [1:0] i_op, input logic [1:0] i_acc,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_before"}, 64'(ready), 64'd1);
    op = i_op; acc_mode = i_acc; src_a = a; src_b = b; hilo_in = hilo;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands changing after acceptance must have no effect.
    src_a = $urandom; src_b = $urandom; op = 2'($urandom); acc_mode = 2'($urandom);
    hilo_in = {$urandom, $urandom};
  endtask

  task automatic run_op(input string tag, input logic [1:0] i_op, input logic [1:0] i_acc,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo);
    logic [31:0] ehi, elo;
    logic edbz;
    int cyc;
    int exp_lat;
    model(i_op, i_acc, a, b, hilo, ehi, elo, edbz);
    exp_lat = W + 2;
`ifdef MUL_DIV_ACC_EN
    if (!i_op[1] && (i_acc == 2'b01 || i_acc == 2'b10)) exp_lat = W + 3;
`endif
    issue(tag, i_op, i_acc, a, b, hilo);
    cyc = 1;
    chk({tag, "_busy"}, 64'(ready), 64'd0);
    while (!opreat_over && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(hi_out), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo_out), 64'(elo));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    @(negedge clk);
    chk({tag, "_ready_after"}, 64'({ready, opreat_over}), 64'b10);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ehi, elo, h0, l0;
    logic edbz, seen;
    int cyc;

    reset = 1'b1; start = 1'b0; op = '0; acc_mode = '0; src_a = '0; src_b = '0;
    hilo_in = '0; cancel = 1'b0; is_busbusy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {59'd0, ready, opreat_over, div_by_zero, 2'b00}, 64'b10000);
    chk("reset_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    chk("multu_max_const", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b01, 2'b00, 32'hFFFF_FFFD, 32'd5, 64'd0);
    chk("mult_neg_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", 2'b11, 2'b00, 32'hFFFF_FFF9, 32'd2, 64'd0);
    chk("div_neg_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", 2'b11, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    chk("div_ovf_const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'b10, 2'b00, 32'd5, 32'd0, 64'd0);
    chk("divu_zero_const", {31'd0, div_by_zero, hi_out, lo_out}, {31'd0, 1'b1, 32'd5, 32'hFFFF_FFFF});
    run_op("div_zero_neg", 2'b11, 2'b00, 32'hFFFF_FFF9, 32'd0, 64'd0);
    run_op("div_minrem", 2'b11, 2'b00, 32'd7, 32'hFFFF_FFFE, 64'd0);

    // Cancel during CALC at cycle 10.
    issue("cancel", 2'b10, 2'b00, 32'd100, 32'd7, 64'd0);
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    chk("cancel_busy_c10", 64'(ready), 64'd0);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_ready_c11", 64'(ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (opreat_over || !ready) seen = 1'b1;
    end
    chk("cancel_no_result", 64'(seen), 64'd0);

    // start together with cancel is not accepted.
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_c1", 64'({ready, opreat_over}), 64'b10);
    @(negedge clk);
    chk("start_cancel_c2", 64'({ready, opreat_over}), 64'b10);

    // Result hold under is_busbusy; start during DONE is ignored.
    is_busbusy = 1'b1;
    model(2'b01, 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 64'd0, ehi, elo, edbz);
    issue("hold", 2'b01, 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 64'd0);
    cyc = 1;
    while (!opreat_over && cyc < 200) begin @(negedge clk); cyc++; end
    chk("hold_latency", 64'(cyc), 64'(W + 2));
    chk("hold_result", {hi_out, lo_out}, {ehi, elo});
    h0 = hi_out; l0 = lo_out;
    for (int i = 0; i < 5; i++) begin
      chk("hold_done", {61'd0, opreat_over, ready, 1'b0}, 64'b100);
      chk("hold_stable", {hi_out, lo_out}, {h0, l0});
      if (i == 1) begin op = 2'b00; src_a = 32'd2; src_b = 32'd2; start = 1'b1; end
      if (i == 2) start = 1'b0;
      if (i == 4) is_busbusy = 1'b0;
      @(negedge clk);
    end
    chk("hold_release", 64'({ready, opreat_over}), 64'b10);
    @(negedge clk);
    chk("hold_start_ignored", 64'({ready, opreat_over}), 64'b10);

    // Accumulate requests (honoured only when the build enables them).
    run_op("madd", 2'b00, 2'b01, 32'd3, 32'd4, 64'h10);
`ifdef MUL_DIV_ACC_EN
    chk("madd_const", {hi_out, lo_out}, 64'h1C);
`else
    chk("madd_const", {hi_out, lo_out}, 64'hC);
`endif
    run_op("msub", 2'b00, 2'b10, 32'd3, 32'd4, 64'd0);
`ifdef MUL_DIV_ACC_EN
    chk("msub_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF4);
`else
    chk("msub_const", {hi_out, lo_out}, 64'hC);
`endif
    run_op("madd_div", 2'b11, 2'b01, 32'd100, 32'd7, 64'h55);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 2'($urandom), 2'($urandom), pick(), pick(), {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of an operation.
    issue("async_rst", 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd7, 64'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_ctrl", {61'd0, ready, opreat_over, div_by_zero}, 64'b100);
    chk("async_rst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_reset", 2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
